// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: Issue/Execute register, LAT-1 execute delay stages and the
// Execute/WriteBack register around an external combinational execute unit.
// Handles ROB backpressure, operand forwarding from own WB and N_BYP
// snoop channels, operand capture while stalled, and early wakeup.
module fu_alu_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned N_BYP   = 2,
    parameter int unsigned LAT     = 1,
    parameter int unsigned PAY_W   = 64,
    parameter int unsigned OTHER_W = 32,
    parameter int unsigned EXC_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          in_dest,
    input  logic                      in_wen,
    input  logic [TAG_W-1:0]          in_rs_tag,
    input  logic [TAG_W-1:0]          in_rt_tag,
    input  logic [DATA_W-1:0]         in_rs_val,
    input  logic [DATA_W-1:0]         in_rt_val,
    input  logic                      in_rs_rdy,
    input  logic                      in_rt_rdy,
    input  logic [PAY_W-1:0]          in_payload,

    input  logic [N_BYP-1:0]          byp_en,
    input  logic [N_BYP*TAG_W-1:0]    byp_tag,
    input  logic [N_BYP*DATA_W-1:0]   byp_data,

    output logic                      ex_valid,
    output logic [DATA_W-1:0]         ex_rs,
    output logic [DATA_W-1:0]         ex_rt,
    output logic [PAY_W-1:0]          ex_payload,
    input  logic [DATA_W-1:0]         ex_result,
    input  logic                      ex_wen,
    input  logic [OTHER_W-1:0]        ex_other,
    input  logic [EXC_W-1:0]          ex_excode,

    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_wen,
    output logic [TAG_W-1:0]          wb_dest,
    output logic [DATA_W-1:0]         wb_result,
    output logic [OTHER_W-1:0]        wb_other,
    output logic [EXC_W-1:0]          wb_excode,

    output logic                      wakeup_en,
    output logic [TAG_W-1:0]          wakeup_dest
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_accept;

    // ------------------------------------------------------------------
    // Issue/Execute register
    // ------------------------------------------------------------------
    logic               r_is_valid;
    logic [TAG_W-1:0]   r_is_dest;
    logic               r_is_inwen;
    logic [TAG_W-1:0]   r_is_rs_tag;
    logic [TAG_W-1:0]   r_is_rt_tag;
    logic [DATA_W-1:0]  r_is_rs_val;
    logic [DATA_W-1:0]  r_is_rt_val;
    logic               r_is_rs_rdy;
    logic               r_is_rt_rdy;
    logic [PAY_W-1:0]   r_is_payload;

    // Resolved operands (value + now-ready flag)
    logic [DATA_W-1:0]  w_rs_res;
    logic [DATA_W-1:0]  w_rt_res;
    logic               w_rs_hit;
    logic               w_rt_hit;

    // ------------------------------------------------------------------
    // Execute/WriteBack register
    // ------------------------------------------------------------------
    logic               r_wb_valid;
    logic               r_wb_exwen;
    logic [TAG_W-1:0]   r_wb_dest;
    logic [DATA_W-1:0]  r_wb_result;
    logic [OTHER_W-1:0] r_wb_other;
    logic [EXC_W-1:0]   r_wb_excode;

    // Stage feeding WB (IS itself when LAT=1, else last delay stage)
    logic               w_fd_valid;
    logic               w_fd_inwen;
    logic               w_fd_exwen;
    logic [TAG_W-1:0]   w_fd_dest;
    logic [DATA_W-1:0]  w_fd_result;
    logic [OTHER_W-1:0] w_fd_other;
    logic [EXC_W-1:0]   w_fd_excode;

    assign w_stall  = r_wb_valid & ~wb_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & ~w_stall & ~flush;

    // Priority: stored-ready, own WB, lowest-index bypass channel, stored.
    function automatic logic [DATA_W:0] f_resolve(
        input logic                    rdy,
        input logic [TAG_W-1:0]        tag,
        input logic [DATA_W-1:0]       val,
        input logic                    own_en,
        input logic [TAG_W-1:0]        own_tag,
        input logic [DATA_W-1:0]       own_val,
        input logic [N_BYP-1:0]        ben,
        input logic [N_BYP*TAG_W-1:0]  btag,
        input logic [N_BYP*DATA_W-1:0] bdat
    );
        logic              hit;
        logic [DATA_W-1:0] res;
        hit = rdy;
        res = val;
        if (!hit && own_en && (own_tag == tag)) begin
            hit = 1'b1;
            res = own_val;
        end
        for (int unsigned c = 0; c < N_BYP; c++) begin
            if (!hit && ben[c] && (btag[c*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
                res = bdat[c*DATA_W +: DATA_W];
            end
        end
        return {hit, res};
    endfunction

    // Resolve both IS operands against stored state and all forward sources
    always_comb begin
        {w_rs_hit, w_rs_res} = f_resolve(r_is_rs_rdy, r_is_rs_tag, r_is_rs_val,
                                         wb_wen, r_wb_dest, r_wb_result,
                                         byp_en, byp_tag, byp_data);
        {w_rt_hit, w_rt_res} = f_resolve(r_is_rt_rdy, r_is_rt_tag, r_is_rt_val,
                                         wb_wen, r_wb_dest, r_wb_result,
                                         byp_en, byp_tag, byp_data);
    end

    // IS register: load on accept, bubble when idle, capture forwards while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_valid   <= 1'b0;
            r_is_dest    <= '0;
            r_is_inwen   <= 1'b0;
            r_is_rs_tag  <= '0;
            r_is_rt_tag  <= '0;
            r_is_rs_val  <= '0;
            r_is_rt_val  <= '0;
            r_is_rs_rdy  <= 1'b0;
            r_is_rt_rdy  <= 1'b0;
            r_is_payload <= '0;
        end else if (flush) begin
            r_is_valid <= 1'b0;
        end else if (w_stall) begin
            // Holding: fold any forward seen this cycle into the stored operand
            r_is_rs_val <= w_rs_res;
            r_is_rt_val <= w_rt_res;
            r_is_rs_rdy <= w_rs_hit;
            r_is_rt_rdy <= w_rt_hit;
        end else if (w_accept) begin
            r_is_valid   <= 1'b1;
            r_is_dest    <= in_dest;
            r_is_inwen   <= in_wen;
            r_is_rs_tag  <= in_rs_tag;
            r_is_rt_tag  <= in_rt_tag;
            r_is_rs_val  <= in_rs_val;
            r_is_rt_val  <= in_rt_val;
            r_is_rs_rdy  <= in_rs_rdy;
            r_is_rt_rdy  <= in_rt_rdy;
            r_is_payload <= in_payload;
        end else begin
            r_is_valid <= 1'b0;
        end
    end

    assign ex_valid   = r_is_valid;
    assign ex_rs      = w_rs_res;
    assign ex_rt      = w_rt_res;
    assign ex_payload = r_is_payload;

    // ------------------------------------------------------------------
    // Execute delay chain (LAT-1 stages)
    // ------------------------------------------------------------------
    generate
        if (LAT > 1) begin : g_dly
            localparam int unsigned ND = LAT - 1;
            logic               r_v     [ND];
            logic               r_inwen [ND];
            logic               r_exwen [ND];
            logic [TAG_W-1:0]   r_dest  [ND];
            logic [DATA_W-1:0]  r_res   [ND];
            logic [OTHER_W-1:0] r_oth   [ND];
            logic [EXC_W-1:0]   r_exc   [ND];

            // Shift the delay chain when not stalled; flush clears valids only
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < ND; i++) begin
                        r_v[i]     <= 1'b0;
                        r_inwen[i] <= 1'b0;
                        r_exwen[i] <= 1'b0;
                        r_dest[i]  <= '0;
                        r_res[i]   <= '0;
                        r_oth[i]   <= '0;
                        r_exc[i]   <= '0;
                    end
                end else begin
                    if (!w_stall) begin
                        r_v[0]     <= r_is_valid;
                        r_inwen[0] <= r_is_inwen;
                        r_exwen[0] <= ex_wen;
                        r_dest[0]  <= r_is_dest;
                        r_res[0]   <= ex_result;
                        r_oth[0]   <= ex_other;
                        r_exc[0]   <= ex_excode;
                        for (int unsigned i = 1; i < ND; i++) begin
                            r_v[i]     <= r_v[i-1];
                            r_inwen[i] <= r_inwen[i-1];
                            r_exwen[i] <= r_exwen[i-1];
                            r_dest[i]  <= r_dest[i-1];
                            r_res[i]   <= r_res[i-1];
                            r_oth[i]   <= r_oth[i-1];
                            r_exc[i]   <= r_exc[i-1];
                        end
                    end
                    if (flush) begin
                        for (int unsigned i = 0; i < ND; i++) begin
                            r_v[i] <= 1'b0;
                        end
                    end
                end
            end

            assign w_fd_valid  = r_v[ND-1];
            assign w_fd_inwen  = r_inwen[ND-1];
            assign w_fd_exwen  = r_exwen[ND-1];
            assign w_fd_dest   = r_dest[ND-1];
            assign w_fd_result = r_res[ND-1];
            assign w_fd_other  = r_oth[ND-1];
            assign w_fd_excode = r_exc[ND-1];
        end else begin : g_nodly
            assign w_fd_valid  = r_is_valid;
            assign w_fd_inwen  = r_is_inwen;
            assign w_fd_exwen  = ex_wen;
            assign w_fd_dest   = r_is_dest;
            assign w_fd_result = ex_result;
            assign w_fd_other  = ex_other;
            assign w_fd_excode = ex_excode;
        end
    endgenerate

    // WB register: advance when not stalled; flush drops a pending ROB write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_exwen  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_result <= '0;
            r_wb_other  <= '0;
            r_wb_excode <= '0;
        end else begin
            if (!w_stall) begin
                r_wb_valid  <= w_fd_valid;
                r_wb_exwen  <= w_fd_exwen;
                r_wb_dest   <= w_fd_dest;
                r_wb_result <= w_fd_result;
                r_wb_other  <= w_fd_other;
                r_wb_excode <= w_fd_excode;
            end
            if (flush) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_wen    = r_wb_valid & r_wb_exwen;
    assign wb_dest   = r_wb_dest;
    assign wb_result = r_wb_result;
    assign wb_other  = r_wb_other;
    assign wb_excode = r_wb_excode;

    // Early wakeup: the op about to enter WB, only if it really moves this cycle
    assign wakeup_en   = w_fd_valid & w_fd_inwen & ~w_stall;
    assign wakeup_dest = w_fd_dest;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed bench for fu_alu_pipe: a LAT=1 and a LAT=3 instance share the
// issue/bypass inputs; each has its own external adder and wb_ready.
module tb_fu_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_wen, in_rs_rdy, in_rt_rdy;
    logic [4:0]  in_dest, in_rs_tag, in_rt_tag;
    logic [31:0] in_rs_val, in_rt_val;
    logic [63:0] in_payload;
    logic [1:0]  byp_en;
    logic [9:0]  byp_tag;
    logic [63:0] byp_data;
    logic        wb_ready1, wb_ready3;

    logic        in_ready1, ex_valid1, wb_valid1, wb_wen1, wakeup_en1, ex_wen1;
    logic [31:0] ex_rs1, ex_rt1, ex_result1, wb_result1, ex_other1, wb_other1;
    logic [63:0] ex_payload1;
    logic [4:0]  ex_excode1, wb_excode1, wb_dest1, wakeup_dest1;

    logic        in_ready3, ex_valid3, wb_valid3, wb_wen3, wakeup_en3, ex_wen3;
    logic [31:0] ex_rs3, ex_rt3, ex_result3, wb_result3, ex_other3, wb_other3;
    logic [63:0] ex_payload3;
    logic [4:0]  ex_excode3, wb_excode3, wb_dest3, wakeup_dest3;

    // External execute units: add, fields taken from the payload
    assign ex_result1 = ex_rs1 + ex_rt1;
    assign ex_wen1    = ex_payload1[0];
    assign ex_excode1 = ex_payload1[5:1];
    assign ex_other1  = ex_payload1[63:32];
    assign ex_result3 = ex_rs3 + ex_rt3;
    assign ex_wen3    = ex_payload3[0];
    assign ex_excode3 = ex_payload3[5:1];
    assign ex_other3  = ex_payload3[63:32];

    fu_alu_pipe #(.LAT(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_dest(in_dest), .in_wen(in_wen),
        .in_rs_tag(in_rs_tag), .in_rt_tag(in_rt_tag), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_rs_rdy(in_rs_rdy), .in_rt_rdy(in_rt_rdy), .in_payload(in_payload),
        .byp_en(byp_en), .byp_tag(byp_tag), .byp_data(byp_data),
        .ex_valid(ex_valid1), .ex_rs(ex_rs1), .ex_rt(ex_rt1), .ex_payload(ex_payload1),
        .ex_result(ex_result1), .ex_wen(ex_wen1), .ex_other(ex_other1), .ex_excode(ex_excode1),
        .wb_valid(wb_valid1), .wb_ready(wb_ready1), .wb_wen(wb_wen1), .wb_dest(wb_dest1),
        .wb_result(wb_result1), .wb_other(wb_other1), .wb_excode(wb_excode1),
        .wakeup_en(wakeup_en1), .wakeup_dest(wakeup_dest1)
    );

    fu_alu_pipe #(.LAT(3)) u3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_dest(in_dest), .in_wen(in_wen),
        .in_rs_tag(in_rs_tag), .in_rt_tag(in_rt_tag), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_rs_rdy(in_rs_rdy), .in_rt_rdy(in_rt_rdy), .in_payload(in_payload),
        .byp_en(byp_en), .byp_tag(byp_tag), .byp_data(byp_data),
        .ex_valid(ex_valid3), .ex_rs(ex_rs3), .ex_rt(ex_rt3), .ex_payload(ex_payload3),
        .ex_result(ex_result3), .ex_wen(ex_wen3), .ex_other(ex_other3), .ex_excode(ex_excode3),
        .wb_valid(wb_valid3), .wb_ready(wb_ready3), .wb_wen(wb_wen3), .wb_dest(wb_dest3),
        .wb_result(wb_result3), .wb_other(wb_other3), .wb_excode(wb_excode3),
        .wakeup_en(wakeup_en3), .wakeup_dest(wakeup_dest3)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rs_v; logic rs_r; logic [4:0] rs_t;
        logic [31:0] rt_v; logic rt_r; logic [4:0] rt_t;
        logic [1:0]  ben;
        logic [4:0]  bt0; logic [31:0] bd0;
        logic [4:0]  bt1; logic [31:0] bd1;
        logic [31:0] exp_rs; logic [31:0] exp_res;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_pay(input int unsigned i);
        return {32'hC0DE_0000 + 32'(i), 26'd0, 5'(i), 1'b1};
    endfunction

    task automatic drive_op(input logic [4:0] dest,
                            input logic [31:0] rsv, input logic rsr, input logic [4:0] rst,
                            input logic [31:0] rtv, input logic rtr, input logic [4:0] rtt,
                            input logic [63:0] pay);
        in_valid   = 1'b1;
        in_wen     = 1'b1;
        in_dest    = dest;
        in_rs_val  = rsv; in_rs_rdy = rsr; in_rs_tag = rst;
        in_rt_val  = rtv; in_rt_rdy = rtr; in_rt_tag = rtt;
        in_payload = pay;
    endtask

    task automatic set_byp(input logic [1:0] en, input logic [4:0] t0, input logic [31:0] d0,
                           input logic [4:0] t1, input logic [31:0] d1);
        byp_en   = en;
        byp_tag  = {t1, t0};
        byp_data = {d1, d0};
    endtask

    initial begin
        vt[0] = '{rs_v:5,   rs_r:1, rs_t:0, rt_v:7, rt_r:1, rt_t:0, ben:2'b00,
                  bt0:0, bd0:0,     bt1:0, bd1:0,     exp_rs:5,     exp_res:12};
        vt[1] = '{rs_v:100, rs_r:0, rs_t:2, rt_v:3, rt_r:1, rt_t:0, ben:2'b10,
                  bt0:0, bd0:0,     bt1:2, bd1:'h20,  exp_rs:'h20,  exp_res:'h23};
        vt[2] = '{rs_v:0,   rs_r:0, rs_t:6, rt_v:0, rt_r:1, rt_t:0, ben:2'b11,
                  bt0:6, bd0:'hA,   bt1:6, bd1:'hB,   exp_rs:'hA,   exp_res:'hA};
        vt[3] = '{rs_v:0,   rs_r:0, rs_t:1, rt_v:0, rt_r:0, rt_t:2, ben:2'b11,
                  bt0:1, bd0:'h100, bt1:2, bd1:'h200, exp_rs:'h100, exp_res:'h300};
        vt[4] = '{rs_v:50,  rs_r:1, rs_t:4, rt_v:1, rt_r:1, rt_t:0, ben:2'b01,
                  bt0:4, bd0:999,   bt1:0, bd1:0,     exp_rs:50,    exp_res:51};
        vt[5] = '{rs_v:40,  rs_r:0, rs_t:3, rt_v:2, rt_r:1, rt_t:0, ben:2'b11,
                  bt0:5, bd0:7,     bt1:6, bd1:8,     exp_rs:40,    exp_res:42};
        vt[6] = '{rs_v:9,   rs_r:0, rs_t:7, rt_v:1, rt_r:1, rt_t:0, ben:2'b00,
                  bt0:7, bd0:'h77,  bt1:7, bd1:'h88,  exp_rs:9,     exp_res:10};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wen = 1'b0;
        in_dest = '0; in_rs_tag = '0; in_rt_tag = '0; in_rs_val = '0; in_rt_val = '0;
        in_rs_rdy = 1'b0; in_rt_rdy = 1'b0; in_payload = '0;
        set_byp(2'b00, 0, 0, 0, 0);
        wb_ready1 = 1'b1; wb_ready3 = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("rst_wb_valid",  64'(wb_valid1),  0);
        chk("rst_wb_wen",    64'(wb_wen1),    0);
        chk("rst_wb_result", 64'(wb_result1), 0);
        chk("rst_ex_valid",  64'(ex_valid1),  0);
        chk("rst_ex_rs",     64'(ex_rs1),     0);
        chk("rst_wakeup",    64'(wakeup_en1), 0);
        chk("rst_in_ready",  64'(in_ready1),  1);
        chk("rst_wb_valid3", 64'(wb_valid3),  0);
        reset = 1'b0;
        tick();

        // Single ops on LAT=1: operand resolution table, latency, wakeup
        for (int i = 0; i < 7; i++) begin
            drive_op(5'(16 + i), vt[i].rs_v, vt[i].rs_r, vt[i].rs_t,
                     vt[i].rt_v, vt[i].rt_r, vt[i].rt_t, mk_pay(i));
            tick();
            in_valid = 1'b0;
            set_byp(vt[i].ben, vt[i].bt0, vt[i].bd0, vt[i].bt1, vt[i].bd1);
            #1;
            chk($sformatf("v%0d_ex_rs", i),       64'(ex_rs1),       64'(vt[i].exp_rs));
            chk($sformatf("v%0d_wb_early", i),    64'(wb_valid1),    0);
            chk($sformatf("v%0d_wakeup", i),      64'(wakeup_en1),   1);
            chk($sformatf("v%0d_wakeup_dst", i),  64'(wakeup_dest1), 64'(16 + i));
            tick();
            set_byp(2'b00, 0, 0, 0, 0);
            chk($sformatf("v%0d_wb_valid", i),    64'(wb_valid1),    1);
            chk($sformatf("v%0d_wb_result", i),   64'(wb_result1),   64'(vt[i].exp_res));
            chk($sformatf("v%0d_wb_dest", i),     64'(wb_dest1),     64'(16 + i));
            chk($sformatf("v%0d_wb_wen", i),      64'(wb_wen1),      1);
            chk($sformatf("v%0d_wb_other", i),    64'(wb_other1),    64'(32'hC0DE_0000 + i));
            chk($sformatf("v%0d_wb_excode", i),   64'(wb_excode1),   64'(i));
        end
        in_valid = 1'b0;
        tick();

        // Back-to-back dependent ops: tag 4 takes tag 3 from own WB
        drive_op(5'd3, 10, 1'b1, 0, 20, 1'b1, 0, mk_pay(1));
        tick();
        drive_op(5'd4, 0, 1'b0, 5'd3, 1, 1'b1, 0, mk_pay(2));
        tick();
        in_valid = 1'b0;
        chk("dep_wb3_result", 64'(wb_result1), 30);
        chk("dep_ex_rs_fwd",  64'(ex_rs1),     30);
        tick();
        chk("dep_wb4_valid",  64'(wb_valid1),  1);
        chk("dep_wb4_dest",   64'(wb_dest1),   4);
        chk("dep_wb4_result", 64'(wb_result1), 31);
        tick();

        // Stall with unresolved op in IS; channel 1 forwards 0x55 once
        drive_op(5'd1, 1, 1'b1, 0, 1, 1'b1, 0, mk_pay(3));
        tick();
        drive_op(5'd7, 0, 1'b0, 5'd9, 2, 1'b1, 0, mk_pay(4));
        tick();
        in_valid  = 1'b0;
        wb_ready1 = 1'b0;
        set_byp(2'b10, 5'd2, 32'h99, 5'd9, 32'h55);
        #1;
        chk("stl1_in_ready", 64'(in_ready1),  0);
        chk("stl1_wakeup",   64'(wakeup_en1), 0);
        chk("stl1_ex_rs",    64'(ex_rs1),     32'h55);
        for (int c = 2; c <= 3; c++) begin
            tick();
            set_byp(2'b00, 0, 0, 0, 0);
            #1;
            chk($sformatf("stl%0d_in_ready", c), 64'(in_ready1),  0);
            chk($sformatf("stl%0d_wakeup", c),   64'(wakeup_en1), 0);
            chk($sformatf("stl%0d_ex_rs", c),    64'(ex_rs1),     32'h55);
            chk($sformatf("stl%0d_wb_dest", c),  64'(wb_dest1),   1);
            chk($sformatf("stl%0d_wb_valid", c), 64'(wb_valid1),  1);
        end
        tick();
        wb_ready1 = 1'b1;
        #1;
        chk("rel_in_ready",    64'(in_ready1),    1);
        chk("rel_wakeup",      64'(wakeup_en1),   1);
        chk("rel_wakeup_dest", 64'(wakeup_dest1), 7);
        tick();
        chk("rel_wb_valid",  64'(wb_valid1),  1);
        chk("rel_wb_dest",   64'(wb_dest1),   7);
        chk("rel_wb_result", 64'(wb_result1), 32'h57);
        repeat (4) tick();

        // LAT=3: four consecutive ops emerge on four consecutive cycles
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive_op(5'(10 + i), 32'(i), 1'b1, 0, 100, 1'b1, 0, mk_pay(i));
            else       in_valid = 1'b0;
            tick();
            if (i == 2) begin
                chk("l3_wb_early",     64'(wb_valid3),    0);
                chk("l3_wakeup",       64'(wakeup_en3),   1);
                chk("l3_wakeup_dest",  64'(wakeup_dest3), 10);
            end
            if (i >= 3) begin
                chk($sformatf("l3_wb%0d_valid", i - 3),  64'(wb_valid3),  1);
                chk($sformatf("l3_wb%0d_dest", i - 3),   64'(wb_dest3),   64'(10 + i - 3));
                chk($sformatf("l3_wb%0d_result", i - 3), 64'(wb_result3), 64'(100 + i - 3));
            end
        end
        in_valid = 1'b0;
        tick();

        // Flush with ops in IS, delay stages and a stalled WB
        for (int i = 0; i < 4; i++) begin
            drive_op(5'(20 + i), 32'(i), 1'b1, 0, 1, 1'b1, 0, mk_pay(i));
            tick();
        end
        chk("fl_pre_wb_dest", 64'(wb_dest3), 20);
        wb_ready3 = 1'b0;
        flush     = 1'b1;
        drive_op(5'd24, 5, 1'b1, 0, 5, 1'b1, 0, mk_pay(5));
        #1;
        chk("fl_in_ready3", 64'(in_ready3), 0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        wb_ready3 = 1'b1;
        chk("fl_ex_valid3", 64'(ex_valid3),  0);
        chk("fl_wb_valid3", 64'(wb_valid3),  0);
        chk("fl_wakeup3",   64'(wakeup_en3), 0);
        chk("fl_ex_valid1", 64'(ex_valid1),  0);
        chk("fl_wb_valid1", 64'(wb_valid1),  0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("fl_drain%0d_wb3", c), 64'(wb_valid3), 0);
            chk($sformatf("fl_drain%0d_ex3", c), 64'(ex_valid3), 0);
        end

        // Reset in the middle of a stall
        drive_op(5'd1, 1, 1'b1, 0, 1, 1'b1, 0, mk_pay(1));
        tick();
        drive_op(5'd7, 32'h33, 1'b0, 5'd9, 2, 1'b1, 0, mk_pay(2));
        tick();
        in_valid  = 1'b0;
        wb_ready1 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rs_stl_ex_valid",  64'(ex_valid1),  0);
        chk("rs_stl_wb_valid",  64'(wb_valid1),  0);
        chk("rs_stl_wb_result", 64'(wb_result1), 0);
        chk("rs_stl_ex_rs",     64'(ex_rs1),     0);
        chk("rs_stl_wakeup",    64'(wakeup_en1), 0);
        reset     = 1'b0;
        wb_ready1 = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
